uart_tx_sched: RTL and testbench

- Shares the processor's single UART transmit line (txd) between two byte requesters.
- Port 0 is the core's output-instruction path; port 1 is the debug/status dumper (e.g. the a0 register dump).
- Round-robin arbitration between ready requesters; the granted byte is serialized as 8N1.
- Sits between the core/debug logic and the board txd pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_ser.sv | 109 ++++++++++
 rtl/uart_tx_sched.sv | 111 +++++++++++
 tb/tb_uart_tx_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit scheduler:
//               serializer state encoding, frame geometry and the idle line
//               level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Serializer state encoding (2 bits)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   DATA_BITS  = 8;     // payload bits per frame
  localparam int   FRAME_BITS = 10;    // start + 8 data + stop
  localparam logic TXD_IDLE   = 1'b1;  // line level when no frame is sent

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_ser.sv
// ============================================================================
// Module      : uart_tx_ser
// Description : 8N1 serializer with baud counter. A byte presented with
//               start_i while idle is latched and shifted out LSB-first,
//               each bit held CLK_PER_BIT cycles.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               start_i      - accept data_i (honoured only while idle)
//               data_i[7:0]  - byte to send
//               busy_o       - frame in progress (registered)
//               txd_o        - serial line, idle high (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 busy_o,
  output logic                 txd_o
);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 busy_q;
  logic                 txd_q;

  // Last cycle of the current bit period
  logic bit_end;
  assign bit_end = (cnt_q == CNT_W'(CLK_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      txd_q   <= TXD_IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= TXD_IDLE;
          if (start_i) begin
            shift_q <= data_i;
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;       // start bit appears the next cycle
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              txd_q   <= TXD_IDLE;  // stop bit
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= TXD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign txd_o  = txd_q;

endmodule : uart_tx_ser

`default_nettype wire

// File: rtl/uart_tx_sched.sv
// ============================================================================
// Module      : uart_tx_sched
// Description : Shares one UART txd line between two byte requesters with
//               round-robin arbitration and an 8N1 serializer.
//               Optional burst locking when UART_TX_SCHED_LOCK_EN is defined:
//               the granted port keeps ownership until it sends a byte with
//               reqN_last=1.
// Ports       : clk, rst                  - clock, sync active-high reset
//               reqN_valid/data/last      - requester N byte interface
//               reqN_ready                - requester N accepted (IDLE only)
//               busy                      - frame in progress
//               txd                       - serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  output logic                 busy,
  output logic                 txd
);

  logic rr_q;        // port granted most recently
  logic locked;      // a burst is open and rr_q owns the line
  logic gnt0, gnt1;
  logic accept;
  logic ser_busy;
  logic [DATA_BITS-1:0] acc_data;

`ifdef UART_TX_SCHED_LOCK_EN
  logic lock_q;
  assign locked = lock_q;
`else
  logic unused_last;
  assign unused_last = req0_last ^ req1_last;
  assign locked      = 1'b0;
`endif

  // Grant: sole valid port, otherwise the port that did not go last.
  // While a burst is open only the owner may be granted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked) begin
      gnt0 = !rr_q && req0_valid;
      gnt1 =  rr_q && req1_valid;
    end else if (req0_valid && req1_valid) begin
      gnt0 =  rr_q;
      gnt1 = !rr_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Ready is held off during reset so a mid-frame reset never accepts
  assign req0_ready = !rst && !ser_busy && gnt0;
  assign req1_ready = !rst && !ser_busy && gnt1;

  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_data = gnt1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= gnt1;
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (accept) begin
      lock_q <= !(gnt1 ? req1_last : req0_last);
    end
  end
`endif

  uart_tx_ser #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .data_i  (acc_data),
    .busy_o  (ser_busy),
    .txd_o   (txd)
  );

  assign busy = ser_busy;

endmodule : uart_tx_sched

`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Directed self-checking bench for uart_tx_sched with
//               CLK_PER_BIT=4. Covers the burst-lock feature when
//               UART_TX_SCHED_LOCK_EN is defined, per-byte round-robin
//               otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_sched;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       busy, txd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int prev_cyc;
  int port;

  uart_tx_sched #(.CLK_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .busy       (busy),
    .txd        (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the port whose handshake completes at the next posedge, then
  // steps past that edge. port=-1 on timeout.
  task automatic wait_accept(output int p);
    p = -1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req0_valid && req0_ready) begin p = 0; break; end
      if (req1_valid && req1_ready) begin p = 1; break; end
      @(negedge clk);
    end
    acc_cyc = cyc;
    if (p >= 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks frame samples lo..hi (sample 0 = first cycle after accept):
  // expected line level, busy high and no ready.
  task automatic check_bits(input logic [7:0] b, input string tag, input int lo, input int hi);
    logic e;
    int   k;
    for (int s = lo; s <= hi; s++) begin
      @(negedge clk);
      k = s / CPB;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      chk($sformatf("%s txd s%0d", tag, s), {31'd0, txd}, {31'd0, e});
      chk($sformatf("%s busy s%0d", tag, s), {31'd0, busy}, 32'd1);
      chk($sformatf("%s ready s%0d", tag, s), {30'd0, req1_ready, req0_ready}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h00; req1_last = 1'b1;

    // Reset: outputs idle and no ready even with both ports valid
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst txd",   {31'd0, txd},  32'd1);
      chk("rst busy",  {31'd0, busy}, 32'd0);
      chk("rst ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    // Single byte 0xA5 on port 0
    req0_valid = 1'b1; req0_data = 8'hA5;
    wait_accept(port);
    chk("a5 port", port, 32'd0);
    req0_valid = 1'b0; req0_data = 8'h00;
    check_bits(8'hA5, "a5", 0, 39);
    @(negedge clk);
    chk("a5 idle busy", {31'd0, busy}, 32'd0);
    chk("a5 idle txd",  {31'd0, txd},  32'd1);

    // Port 1 alone: rr pointer moves to 1
    req1_valid = 1'b1; req1_data = 8'h3C;
    wait_accept(port);
    chk("3c port", port, 32'd1);
    req1_valid = 1'b0;
    check_bits(8'h3C, "3c", 0, 39);

    // Both valid continuously: 0,1,0,1 spaced 41 cycles
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(port);
      chk($sformatf("rr order %0d", i), port, i % 2);
      if (i > 0) chk($sformatf("rr period %0d", i), acc_cyc - prev_cyc, 32'd41);
      prev_cyc = acc_cyc;
      check_bits((i % 2) ? 8'h22 : 8'h11, $sformatf("rr%0d", i), 0, 39);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset during cycle 15 of a frame (data bit 2 of 0x5A = 0)
    req0_valid = 1'b1; req0_data = 8'h5A;
    wait_accept(port);
    chk("5a port", port, 32'd0);
    check_bits(8'h5A, "5a pre", 0, 14);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst txd",   {31'd0, txd},  32'd1);
    chk("midrst busy",  {31'd0, busy}, 32'd0);
    chk("midrst ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    rst = 1'b0;
    wait_accept(port);
    chk("post rst port", port, 32'd0);
    req0_valid = 1'b0;
    check_bits(8'h5A, "5a post", 0, 39);

    // Inputs changed while busy are ignored; held byte sent intact
    req1_valid = 1'b1; req1_data = 8'h96;
    wait_accept(port);
    chk("96 port", port, 32'd1);
    req1_valid = 1'b0; req1_data = 8'hFF;
    check_bits(8'h96, "96a", 0, 4);
    req1_valid = 1'b1; req1_data = 8'hC3;
    req0_valid = 1'b1; req0_data = 8'h77;
    check_bits(8'h96, "96b", 5, 39);
    wait_accept(port);
    chk("77 port", port, 32'd0);
    req0_valid = 1'b0;
    check_bits(8'h77, "77", 0, 39);
    wait_accept(port);
    chk("c3 port", port, 32'd1);
    req1_valid = 1'b0;
    check_bits(8'hC3, "c3", 0, 39);

    // Burst of three bytes on port 1 while port 0 waits
    req1_valid = 1'b1; req1_data = 8'hB1; req1_last = 1'b0;
    wait_accept(port);
    chk("b1 port", port, 32'd1);
    req1_data = 8'hB2;
    req0_valid = 1'b1; req0_data = 8'h44; req0_last = 1'b1;
    check_bits(8'hB1, "b1", 0, 39);
`ifdef UART_TX_SCHED_LOCK_EN
    wait_accept(port);
    chk("b2 port", port, 32'd1);
    req1_valid = 1'b0;
    check_bits(8'hB2, "b2", 0, 39);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("lock hold ready %0d", i), {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    req1_valid = 1'b1; req1_data = 8'hB3; req1_last = 1'b1;
    wait_accept(port);
    chk("b3 port", port, 32'd1);
    req1_valid = 1'b0;
    check_bits(8'hB3, "b3", 0, 39);
    wait_accept(port);
    chk("44 port", port, 32'd0);
    req0_valid = 1'b0;
    check_bits(8'h44, "44", 0, 39);
`else
    wait_accept(port);
    chk("44 port", port, 32'd0);
    req0_valid = 1'b0;
    check_bits(8'h44, "44", 0, 39);
    wait_accept(port);
    chk("b2 port", port, 32'd1);
    req1_valid = 1'b0;
    check_bits(8'hB2, "b2", 0, 39);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_sched

`default_nettype wire
